// File: rtl/queue2_pkg.sv
// queue2_pkg: shared defaults and head-cache occupancy encoding for queue2
package queue2_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {OCC_0 = 2'd0, OCC_1 = 2'd1, OCC_2 = 2'd2} occ_e;
endpackage

// File: rtl/queue2_mem.sv
// queue2_mem: simple dual-port memory, one write port, registered read port
module queue2_mem
  import queue2_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  // write port and one-cycle-latency read port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/queue2.sv
// queue2: FWFT queue with a two-word head cache in front of a 2**AW-word memory
module queue2
  import queue2_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in,
  input  logic          push,
  input  logic          pop,
  output logic [DW-1:0] s0,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  localparam logic [AW:0] CAP = (AW+1)'(1) << AW;
  logic [DW-1:0] s0_q, s0_d, s1_q, s1_d, rd_data;
  occ_e          occ_q, occ_d;
  logic          rd_pend_q;
  logic [AW:0]   count_q, count_d, m_q, m_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [1:0]    c, k, after_pop;
  logic          pop_ok, push_ok, byp, rd_en, wr_en;
  assign c         = occ_q;
  assign pop_ok    = pop & (count_q != '0);
  assign push_ok   = push & ((count_q != CAP) | pop_ok);
  assign after_pop = c + {1'b0, rd_pend_q} - {1'b0, pop_ok};
  assign byp       = push_ok & (m_q == '0) & ~after_pop[1];
  assign rd_en     = (m_q != '0) & ~after_pop[1];
  assign wr_en     = push_ok & ~byp;
  assign count_d   = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign m_d       = m_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  assign s0        = s0_q;
  assign empty     = count_q == '0;
  assign full      = count_q == CAP;
  assign count     = count_q;
  queue2_mem #(.AW(AW), .DW(DW)) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (in),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );
  // shift out the popped head, then append the landing read word and a bypassed push in order
  always_comb begin
    k    = c - {1'b0, pop_ok};
    s0_d = pop_ok ? s1_q : s0_q;
    s1_d = s1_q;
    if (rd_pend_q) begin
      s0_d = (k == 2'd0) ? rd_data : s0_d;
      s1_d = (k == 2'd0) ? s1_d : rd_data;
      k    = k + 2'd1;
    end
    if (byp) begin
      s0_d = (k == 2'd0) ? in : s0_d;
      s1_d = (k == 2'd0) ? s1_d : in;
      k    = k + 2'd1;
    end
    occ_d = occ_e'(k);
  end
  // state registers; reset drops cache, pointers and any read in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q      <= '0;
      s1_q      <= '0;
      occ_q     <= OCC_0;
      rd_pend_q <= 1'b0;
      count_q   <= '0;
      m_q       <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      occ_q     <= occ_d;
      rd_pend_q <= rd_en;
      count_q   <= count_d;
      m_q       <= m_d;
      wr_ptr_q  <= wr_ptr_q + AW'(wr_en);
      rd_ptr_q  <= rd_ptr_q + AW'(rd_en);
    end
  end
endmodule

// File: tb/tb_queue2.sv
// tb_queue2: directed self-checking bench for queue2 with AW=3, DW=16
module tb_queue2;
  logic        clk = 1'b0;
  logic        reset, push, pop;
  logic [15:0] in, s0;
  logic        empty, full;
  logic [3:0]  count;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  queue2 #(.AW(3), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .push  (push),
    .pop   (pop),
    .s0    (s0),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; push = 1'b0; pop = 1'b0; in = '0;
    step(); step();
    reset = 1'b0;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
    tests++; if (s0 !== 16'h0000) begin fails++; $display("FAIL reset_s0 got %h want 0000", s0); end
  endtask

  task automatic test_single_push;
    push = 1'b1; in = 16'h0011;
    step();
    push = 1'b0;
    tests++; if (s0 !== 16'h0011) begin fails++; $display("FAIL single_s0 got %h want 0011", s0); end
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL single_empty got %b want 0", empty); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1; in = 16'(i);
      step();
      tests++; if (s0 !== 16'h0001) begin fails++; $display("FAIL fill_head i=%0d got %h want 0001", i, s0); end
    end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full got %b want 1", full); end
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL fill_count got %0d want 8", count); end
    in = 16'h0009;
    step();
    push = 1'b0;
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL overflow_count got %0d want 8", count); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL overflow_full got %b want 1", full); end
    pop = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tests++; if (s0 !== 16'(i)) begin fails++; $display("FAIL drain_s0 i=%0d got %h want %h", i, s0, 16'(i)); end
      step();
    end
    pop = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %b want 1", empty); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL drain_count got %0d want 0", count); end
  endtask

  task automatic test_interleave;
    logic [15:0] q[$];
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; in = 16'h0100 + 16'(i);
      q.push_back(in);
      step();
    end
    tests++; if (count !== 4'd5) begin fails++; $display("FAIL inter_start_count got %0d want 5", count); end
    pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in = 16'h0200 + 16'(i);
      tests++; if (s0 !== q[0]) begin fails++; $display("FAIL inter_s0 cyc=%0d got %h want %h", i, s0, q[0]); end
      void'(q.pop_front());
      q.push_back(in);
      step();
      tests++; if (count !== 4'd5) begin fails++; $display("FAIL inter_count cyc=%0d got %0d want 5", i, count); end
    end
    push = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++; if (s0 !== q[0]) begin fails++; $display("FAIL inter_drain_s0 i=%0d got %h want %h", i, s0, q[0]); end
      void'(q.pop_front());
      step();
    end
    pop = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL inter_empty got %b want 1", empty); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1; in = 16'h0300 + 16'(i);
      step();
    end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fpp_full got %b want 1", full); end
    pop = 1'b1; in = 16'h00AA;
    step();
    push = 1'b0;
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL fpp_count got %0d want 8", count); end
    for (int i = 2; i <= 8; i++) begin
      tests++; if (s0 !== 16'h0300 + 16'(i)) begin fails++; $display("FAIL fpp_s0 i=%0d got %h want %h", i, s0, 16'h0300 + 16'(i)); end
      step();
    end
    tests++; if (s0 !== 16'h00AA) begin fails++; $display("FAIL fpp_last got %h want 00aa", s0); end
    step();
    pop = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fpp_empty got %b want 1", empty); end
  endtask

  task automatic test_empty_push_pop;
    push = 1'b1; pop = 1'b1; in = 16'h0055;
    step();
    push = 1'b0; pop = 1'b0;
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL epp_count got %0d want 1", count); end
    tests++; if (s0 !== 16'h0055) begin fails++; $display("FAIL epp_s0 got %h want 0055", s0); end
    pop = 1'b1;
    step();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL epp_pop_count got %0d want 0", count); end
    step();
    pop = 1'b0;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL underflow_count got %0d want 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL underflow_empty got %b want 1", empty); end
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 6; i++) begin
      push = 1'b1; in = 16'h0400 + 16'(i);
      step();
    end
    push = 1'b0;
    tests++; if (count !== 4'd6) begin fails++; $display("FAIL rst_mid_fill got %0d want 6", count); end
    pop = 1'b1; reset = 1'b1;
    step();
    pop = 1'b0; reset = 1'b0;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL rst_mid_count got %0d want 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_mid_empty got %b want 1", empty); end
    push = 1'b1; in = 16'h0077;
    step();
    push = 1'b0;
    tests++; if (s0 !== 16'h0077) begin fails++; $display("FAIL rst_mid_s0 got %h want 0077", s0); end
    step();
    tests++; if (s0 !== 16'h0077) begin fails++; $display("FAIL rst_mid_hold got %h want 0077", s0); end
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL rst_mid_after got %0d want 1", count); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_mid_drain got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_interleave();
    test_full_push_pop();
    test_empty_push_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
